// File: rtl/stack_pkg.sv
// Shared types and defaults for the two-requester stack arbiter.
package stack_pkg;

  localparam int unsigned DEPTH_DEFAULT = 32;
  localparam int unsigned WIDTH_DEFAULT = 8;

  typedef enum logic {
    OP_PUSH = 1'b0,
    OP_POP  = 1'b1
  } op_e;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  typedef enum logic [2:0] {
    IDLE,
    PUSH_WR,
    PUSH_INC,
    POP_DEC,
    POP_RD,
    RESP
  } state_e;

endpackage

// File: rtl/stack_mem.sv
// Stack storage: one synchronous write port, one asynchronous read port, no reset.
module stack_mem
  import stack_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stack_arbiter.sv
// Round-robin arbiter granting two requesters push/pop access to a shared stack,
// one operation at a time.
module stack_arbiter
  import stack_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   a_req,
  input  logic                   a_op,
  input  logic [WIDTH-1:0]       a_wdata,
  output logic                   a_ack,
  output logic [WIDTH-1:0]       a_rdata,
  output logic                   a_err,
  input  logic                   b_req,
  input  logic                   b_op,
  input  logic [WIDTH-1:0]       b_wdata,
  output logic                   b_ack,
  output logic [WIDTH-1:0]       b_rdata,
  output logic                   b_err,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [AW:0] SP_ONE  = (AW+1)'(1);
  localparam logic [AW:0] SP_FULL = (AW+1)'(DEPTH);

  state_e           state, state_n;
  logic [AW:0]      sp;
  req_id_e          gnt_id, last_gnt, arb_id;
  op_e              arb_op;
  logic             arb_rej, gnt_rej, any_req, mem_we;
  logic [WIDTH-1:0] gnt_wdata, mem_rdata, a_rdata_q, b_rdata_q;

  // B wins only when alone or when A was the last one served.
  assign any_req = a_req | b_req;
  assign arb_id  = (b_req && (!a_req || last_gnt == REQ_A)) ? REQ_B : REQ_A;
  assign arb_op  = (arb_id == REQ_B) ? op_e'(b_op) : op_e'(a_op);
  assign arb_rej = (arb_op == OP_PUSH) ? full : empty;

  always_comb begin
    state_n = state;
    mem_we  = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          if (arb_rej)                state_n = RESP;
          else if (arb_op == OP_PUSH) state_n = PUSH_WR;
          else                        state_n = POP_DEC;
        end
      end
      PUSH_WR: begin
        mem_we  = 1'b1;
        state_n = PUSH_INC;
      end
      PUSH_INC: state_n = RESP;
      POP_DEC:  state_n = POP_RD;
      POP_RD:   state_n = RESP;
      RESP:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sp        <= '0;
      last_gnt  <= REQ_B;
      gnt_id    <= REQ_A;
      gnt_rej   <= 1'b0;
      gnt_wdata <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt_id    <= arb_id;
            gnt_rej   <= arb_rej;
            gnt_wdata <= (arb_id == REQ_B) ? b_wdata : a_wdata;
          end
        end
        PUSH_INC: sp <= sp + SP_ONE;
        POP_DEC:  sp <= sp - SP_ONE;
        POP_RD: begin
          if (gnt_id == REQ_A) a_rdata_q <= mem_rdata;
          else                 b_rdata_q <= mem_rdata;
        end
        RESP:     last_gnt <= gnt_id;
        default: ;
      endcase
    end
  end

  stack_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (sp[AW-1:0]),
    .wdata (gnt_wdata),
    .raddr (sp[AW-1:0]),
    .rdata (mem_rdata)
  );

  assign a_ack   = (state == RESP) && (gnt_id == REQ_A);
  assign b_ack   = (state == RESP) && (gnt_id == REQ_B);
  assign a_err   = a_ack && gnt_rej;
  assign b_err   = b_ack && gnt_rej;
  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;
  assign full    = (sp == SP_FULL);
  assign empty   = (sp == '0);
  assign count   = sp;

endmodule

// File: tb/tb_stack_arbiter.sv
// Randomized self-checking bench for stack_arbiter against a queue-based stack model.
module tb_stack_arbiter;
  import stack_pkg::*;

  localparam int unsigned DEPTH = 32;
  localparam int unsigned WIDTH = 8;

  logic             clk, rst;
  logic             a_req, a_op, b_req, b_op;
  logic [WIDTH-1:0] a_wdata, b_wdata, a_rdata, b_rdata;
  logic             a_ack, a_err, b_ack, b_err, full, empty;
  logic [5:0]       count;

  int tests = 0;
  int fails = 0;

  logic [7:0] stk[$];
  logic [7:0] m_a, m_b;
  bit         m_last_b;

  stack_arbiter #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_op(a_op), .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_op(b_op), .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
    .full(full), .empty(empty), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit model_apply(input bit is_b, input bit op, input logic [7:0] d);
    logic [7:0] rd;
    m_last_b = is_b;
    if (op) begin
      if (stk.size() == 0) return 1'b1;
      rd = stk.pop_back();
      if (is_b) m_b = rd; else m_a = rd;
    end else begin
      if (stk.size() == DEPTH) return 1'b1;
      stk.push_back(d);
    end
    return 1'b0;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; a_req = 1'b0; b_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    stk.delete();
    m_a = '0; m_b = '0; m_last_b = 1'b1;
  endtask

  task automatic single_op(input string tag, input bit is_b, input bit op, input logic [7:0] d);
    int lat, got;
    bit exp_rej, oth_ack, own_err;
    logic [7:0] own_rd, exp_own, exp_oth;
    exp_rej = model_apply(is_b, op, d);
    lat     = exp_rej ? 1 : 3;
    exp_own = is_b ? m_b : m_a;
    exp_oth = is_b ? m_a : m_b;
    @(negedge clk);
    if (is_b) begin b_req = 1'b1; b_op = op; b_wdata = d; end
    else      begin a_req = 1'b1; a_op = op; a_wdata = d; end
    got = 0; oth_ack = 1'b0; own_err = 1'b0; own_rd = 'x;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if ((is_b ? a_ack : b_ack) !== 1'b0) oth_ack = 1'b1;
      if ((is_b ? b_ack : a_ack) === 1'b1) begin
        got = c;
        own_err = is_b ? b_err : a_err;
        own_rd  = is_b ? b_rdata : a_rdata;
        break;
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    tests++; if (got != lat) begin fails++; $display("FAIL %s latency: got %0d expected %0d", tag, got, lat); end
    tests++; if (own_err !== exp_rej) begin fails++; $display("FAIL %s err: got %b expected %b", tag, own_err, exp_rej); end
    tests++; if (own_rd !== exp_own) begin fails++; $display("FAIL %s rdata: got %h expected %h", tag, own_rd, exp_own); end
    tests++; if ((is_b ? a_rdata : b_rdata) !== exp_oth) begin fails++; $display("FAIL %s other_rdata: got %h expected %h", tag, is_b ? a_rdata : b_rdata, exp_oth); end
    tests++; if (oth_ack) begin fails++; $display("FAIL %s other_ack: got 1 expected 0", tag); end
    tests++; if (count !== 6'(stk.size())) begin fails++; $display("FAIL %s count: got %0d expected %0d", tag, count, stk.size()); end
    tests++; if (full !== (stk.size() == DEPTH) || empty !== (stk.size() == 0)) begin
      fails++; $display("FAIL %s flags: got full=%b empty=%b expected size %0d", tag, full, empty, stk.size());
    end
  endtask

  task automatic contend(input string tag, input bit op_a, input logic [7:0] d_a, input bit op_b, input logic [7:0] d_b);
    bit w_b, rej_w, rej_l, ea, eb;
    int ta, tb, lat_w, exp_ta, exp_tb;
    w_b   = !m_last_b;
    rej_w = w_b ? model_apply(1'b1, op_b, d_b) : model_apply(1'b0, op_a, d_a);
    rej_l = w_b ? model_apply(1'b0, op_a, d_a) : model_apply(1'b1, op_b, d_b);
    lat_w = rej_w ? 1 : 3;
    exp_ta = w_b ? lat_w + 1 + (rej_l ? 1 : 3) : lat_w;
    exp_tb = w_b ? lat_w : lat_w + 1 + (rej_l ? 1 : 3);
    @(negedge clk);
    a_req = 1'b1; a_op = op_a; a_wdata = d_a;
    b_req = 1'b1; b_op = op_b; b_wdata = d_b;
    ta = 0; tb = 0; ea = 1'b0; eb = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (a_ack === 1'b1 && ta == 0) begin ta = c; ea = a_err; a_req = 1'b0; end
      if (b_ack === 1'b1 && tb == 0) begin tb = c; eb = b_err; b_req = 1'b0; end
      if (ta != 0 && tb != 0) break;
    end
    a_req = 1'b0; b_req = 1'b0;
    tests++; if (ta != exp_ta) begin fails++; $display("FAIL %s a_ack_time: got %0d expected %0d", tag, ta, exp_ta); end
    tests++; if (tb != exp_tb) begin fails++; $display("FAIL %s b_ack_time: got %0d expected %0d", tag, tb, exp_tb); end
    tests++; if (ea !== (w_b ? rej_l : rej_w)) begin fails++; $display("FAIL %s a_err: got %b expected %b", tag, ea, w_b ? rej_l : rej_w); end
    tests++; if (eb !== (w_b ? rej_w : rej_l)) begin fails++; $display("FAIL %s b_err: got %b expected %b", tag, eb, w_b ? rej_w : rej_l); end
    tests++; if (a_rdata !== m_a || b_rdata !== m_b) begin
      fails++; $display("FAIL %s rdata: got a=%h b=%h expected a=%h b=%h", tag, a_rdata, b_rdata, m_a, m_b);
    end
    tests++; if (count !== 6'(stk.size())) begin fails++; $display("FAIL %s count: got %0d expected %0d", tag, count, stk.size()); end
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (count !== 6'd0 || empty !== 1'b1 || full !== 1'b0) begin
      fails++; $display("FAIL reset_flags: got count=%0d empty=%b full=%b expected 0/1/0", count, empty, full);
    end
    tests++; if ({a_ack, a_err, b_ack, b_err} !== 4'b0 || a_rdata !== 8'h00 || b_rdata !== 8'h00) begin
      fails++; $display("FAIL reset_outputs: got ack/err=%b%b%b%b rdata=%h/%h expected all zero", a_ack, a_err, b_ack, b_err, a_rdata, b_rdata);
    end
  endtask

  task automatic test_directed();
    single_op("a_push_5a", 1'b0, 1'b0, 8'h5A);
    single_op("b_pop_5a", 1'b1, 1'b1, 8'h00);
  endtask

  task automatic test_contention();
    do_reset();
    contend("both_push", 1'b0, 8'h11, 1'b0, 8'h22);
    single_op("pop_after_contend", 1'b0, 1'b1, 8'h00);
    single_op("pop_second", 1'b1, 1'b1, 8'h00);
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < DEPTH; i++) single_op("fill_push", i[0], 1'b0, 8'($urandom));
    tests++; if (full !== 1'b1 || count !== 6'd32) begin fails++; $display("FAIL fill_full: got full=%b count=%0d expected 1/32", full, count); end
    single_op("overflow_push", 1'b0, 1'b0, 8'hEE);
    for (int i = 0; i < DEPTH; i++) single_op("drain_pop", i[1], 1'b1, 8'h00);
    single_op("underflow_a", 1'b0, 1'b1, 8'h00);
    single_op("underflow_b", 1'b1, 1'b1, 8'h00);
  endtask

  task automatic test_reset_mid_op();
    int acks;
    do_reset();
    single_op("pre_abort_push", 1'b0, 1'b0, 8'h33);
    @(negedge clk);
    a_req = 1'b1; a_op = 1'b0; a_wdata = 8'h44;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; a_req = 1'b0;
    acks = 0;
    @(negedge clk);
    if (a_ack !== 1'b0 || b_ack !== 1'b0) acks++;
    tests++; if (dut.state !== IDLE) begin fails++; $display("FAIL abort_state: got %0d expected IDLE", dut.state); end
    tests++; if (count !== 6'd0) begin fails++; $display("FAIL abort_count: got %0d expected 0", count); end
    rst = 1'b0;
    stk.delete(); m_a = '0; m_b = '0; m_last_b = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (a_ack !== 1'b0 || b_ack !== 1'b0) acks++;
    end
    tests++; if (acks != 0) begin fails++; $display("FAIL abort_no_ack: got %0d acks expected 0", acks); end
    single_op("post_abort_pop", 1'b1, 1'b1, 8'h00);
    contend("post_abort_contend", 1'b0, 8'h55, 1'b1, 8'h00);
  endtask

  task automatic test_random();
    for (int i = 0; i < 250; i++) begin
      bit op_a, op_b;
      op_a = ($urandom_range(0, 99) < 55) ? 1'b0 : 1'b1;
      op_b = ($urandom_range(0, 99) < 45) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 3) == 0) contend("rand_contend", op_a, 8'($urandom), op_b, 8'($urandom));
      else single_op("rand_single", 1'($urandom), op_a, 8'($urandom));
    end
  endtask

  initial begin
    rst = 1'b1; a_req = 1'b0; b_req = 1'b0;
    a_op = 1'b0; b_op = 1'b0; a_wdata = '0; b_wdata = '0;
    m_a = '0; m_b = '0; m_last_b = 1'b1;
    test_reset();
    test_directed();
    test_contention();
    test_fill();
    test_reset_mid_op();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stack_arbiter.md
STACK_ARBITER -- requirements
Module: stack_arbiter

Interface
REQ-001 Parameter DEPTH, default 32, number of stack entries; a power of two, at least 2.
REQ-002 Parameter WIDTH, default 8, data width in bits.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 a_req  input  1  requester A operation request; held until a_ack.
REQ-006 a_op  input  1  requester A op: 0 = push, 1 = pop; stable while a_req high.
REQ-007 a_wdata  input  WIDTH  requester A push data; stable while a_req high.
REQ-008 a_ack  output  1  one-cycle completion pulse to A.
REQ-009 a_rdata  output  WIDTH  pop result for A; held until A's next successful pop.
REQ-010 a_err  output  1  pulses with a_ack when A's op was rejected (overflow or underflow).
REQ-011 b_req, b_op, b_wdata, b_ack, b_rdata, b_err  same directions, widths and meanings for requester B.
REQ-012 full  output  1  high when count == DEPTH.
REQ-013 empty  output  1  high when count == 0.
REQ-014 count  output  $clog2(DEPTH)+1  current number of stored entries.

Function
REQ-015 The FSM SHALL have states IDLE, PUSH_WR, PUSH_INC, POP_DEC, POP_RD, RESP.
REQ-016 In IDLE with any req high: grant one requester, latch its id, op and wdata, then transition.
REQ-017 Arbitration SHALL be round-robin: when both request, grant the requester not granted last; a sole requester is always granted.
REQ-018 Granted push, not full: IDLE->PUSH_WR (mem[sp]<=wdata) ->PUSH_INC (sp<=sp+1) ->RESP.
REQ-019 Granted pop, not empty: IDLE->POP_DEC (sp<=sp-1) ->POP_RD (rdata<=mem[sp]) ->RESP.
REQ-020 Push when full, or pop when empty: IDLE->RESP with err; sp, memory and rdata unchanged.
REQ-021 RESP: pulse ack (and err if rejected) to the granted requester only, update last-grant, go to IDLE.
REQ-022 Latency: req sampled in IDLE at cycle N gives ack at N+3 on success and N+1 on rejection.
REQ-023 req is not sampled in RESP; the requester drops req the cycle after ack, so IDLE re-arbitrates from N+4.
REQ-024 Throughput: at most one operation in flight; no back-to-back grants without an intervening IDLE.
REQ-025 count SHALL equal sp; sp never wraps: push at DEPTH and pop at 0 are rejected, not performed.
REQ-026 full and empty are combinational from sp and are never both high.
REQ-027 The non-granted requester's outputs SHALL be unaffected by the other requester's operation.

Reset
REQ-028 On rst: state=IDLE, sp=0, last-grant=B (A wins the first contention), all ack/err=0, a_rdata=b_rdata=0.
REQ-029 Reset mid-operation SHALL abort the operation with no ack; memory contents are don't-care after reset.

Structure
REQ-030 Package stack_pkg SHALL hold the op encoding (OP_PUSH=0, OP_POP=1), the FSM state enum and the DEPTH/WIDTH defaults.
REQ-031 Storage SHALL be a sub-module stack_mem (DEPTH x WIDTH, one synchronous write port, one read port); the arbiter owns sp and the FSM.

Verification
REQ-032 After reset, A pushes 0x5A -> a_ack at N+3, a_err=0, count=1, empty=0.
REQ-033 Then B pops -> b_ack at N+3, b_rdata=0x5A, count=0, a_rdata unchanged (0x00).
REQ-034 A and B request push 0x11/0x22 in the same cycle after reset -> A is acked first, then B; a pop returns 0x22.
REQ-035 Fill with 32 pushes (count=32, full=1); a 33rd push -> ack at N+1, err=1, count stays 32; then 32 pops return data in reverse order.
REQ-036 Pop on empty -> ack at N+1, err=1, rdata held at its prior value; rst asserted in PUSH_INC -> no ack, count=0, state IDLE.
